// File: rtl/spram_arbiter_if.sv
// Requester-side bus for one port of the SPRAM arbiter: a valid/ready
// request channel plus the registered read-response channel.
interface spram_arbiter_if #(
  parameter int ADDR_WIDTH = 14
) ();
  logic                  valid;
  logic                  write;
  logic [3:0]            wmask;
  logic [31:0]           wdata;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (
    output valid, write, wmask, wdata, addr,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, write, wmask, wdata, addr,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/spram_arbiter.sv
// Shares one single-port SPRAM between the pipeline port (A, fixed priority)
// and a secondary master (B). B is forced through after STARVE_LIMIT cycles
// of losing to A, and a read tag steers the registered SPRAM data back to
// whichever port issued the read one cycle earlier.
module spram_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  spram_arbiter_if.slave        port_a,
  spram_arbiter_if.slave        port_b,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       grant_a;
  logic       grant_b;
  logic       force_b;
  logic [3:0] wait_cnt_d, wait_cnt_q;
  logic [1:0] rd_tag_d, rd_tag_q;

  // Grant decision, SPRAM mux and next-state for the counter and read tag.
  always_comb begin
    force_b = (wait_cnt_q == LIMIT);
    grant_b = port_b.valid & (~port_a.valid | force_b);
    grant_a = port_a.valid & ~grant_b;

    port_a.ready = grant_a;
    port_b.ready = grant_b;

    // With no grant the address follows A so the SPRAM does a harmless read.
    if (grant_b) begin
      mem_addr  = port_b.addr;
      mem_wdata = port_b.wdata;
      mem_wmask = port_b.wmask;
    end else begin
      mem_addr  = port_a.addr;
      mem_wdata = port_a.wdata;
      mem_wmask = port_a.wmask;
    end
    mem_write = (grant_a & port_a.write) | (grant_b & port_b.write);

    wait_cnt_d = wait_cnt_q;
    if (grant_b || !port_b.valid) begin
      wait_cnt_d = 4'd0;
    end else if (grant_a && (wait_cnt_q != LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    rd_tag_d = {grant_b & ~port_b.write, grant_a & ~port_a.write};

    port_a.rvalid = rd_tag_q[0];
    port_b.rvalid = rd_tag_q[1];
    port_a.rdata  = mem_rdata;
    port_b.rdata  = mem_rdata;
  end

  // Starvation counter and read-response tag, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt_q <= 4'd0;
      rd_tag_q   <= 2'b00;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-port arbiter that shares the 64 KiB single-port SPRAM main memory between the pipeline data/instruction port (port A) and a secondary bus master such as a DMA or debug loader (port B). Each cycle it grants at most one request to the SPRAM. It uses fixed priority for port A, with a starvation limit that guarantees port B forward progress. It tracks which port issued each read so the registered SPRAM read data returns to the correct requester one cycle later.

## Interface
- `ADDR_WIDTH`, 14: word-address width of the SPRAM (16K × 32 bit).
- `STARVE_LIMIT`, 4: consecutive cycles port B may wait while port A is granted before B is forced to win. Legal range 1..15.

- `clk`  in  1: system clock; all state on rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `a_valid`  in  1: port A request.
- `a_write`  in  1: port A write (1) / read (0).
- `a_wmask`  in  4: port A byte write enables.
- `a_wdata`  in  32: port A write data.
- `a_addr`  in  ADDR_WIDTH: port A word address.
- `a_ready`  out  1: port A request accepted this cycle.
- `a_rvalid`  out  1: `a_rdata` valid this cycle.
- `a_rdata`  out  32: port A read data.
- `b_*`: same eight signals for port B.
- `mem_write`  out  1: SPRAM write enable.
- `mem_wmask`  out  4: SPRAM byte mask.
- `mem_wdata`  out  32: SPRAM write data.
- `mem_addr`  out  ADDR_WIDTH: SPRAM word address.
- `mem_rdata`  in  32: SPRAM data out, valid one cycle after the address.

## Operation
- Grant decision (combinational, per cycle):
  - `force_b = (wait_cnt == STARVE_LIMIT)`.
  - `grant_b = b_valid & (~a_valid | force_b)`.
  - `grant_a = a_valid & ~grant_b`.
- Ready signals: `a_ready = grant_a` and `b_ready = grant_b`. A requester holds all request fields stable until it sees ready high. A request is accepted in the cycle where valid and ready are both high.
- Memory mux:
  - `mem_addr`, `mem_wdata` and `mem_wmask` come from port B when `grant_b`, otherwise from port A.
  - `mem_write = (grant_a & a_write) | (grant_b & b_write)`.
  - With no grant, `mem_write` is 0. The address follows port A, so the SPRAM performs a harmless read.
- Starvation counter `wait_cnt` (4 bits, saturating at `STARVE_LIMIT`):
  - Increments when `b_valid & grant_a`.
  - Clears when `grant_b` or `~b_valid`.
  - Holds when neither port is granted and `b_valid` is high. This case is unreachable, so it is a don't-care.
- Read tag register `rd_tag[1:0]`:
  - Bit 0 is set for a granted port A read, bit 1 for a granted port B read, and the register is 00 otherwise.
  - It updates every cycle.
  - `a_rvalid = rd_tag[0]` and `b_rvalid = rd_tag[1]`.
  - `a_rdata` and `b_rdata` are both driven directly from `mem_rdata`. Data is qualified only by rvalid.
- Writes produce no rvalid response.
- Back-to-back reads are fully pipelined: one grant per cycle, with responses in grant order.

## Timing
- Reset values, asserted asynchronously while `rstn` = 0: `wait_cnt` = 0 and `rd_tag` = 00, so `a_rvalid` = `b_rvalid` = 0.
- During reset `a_ready` and `b_ready` follow the combinational grant logic. Requesters are themselves held in reset, so their valids are low.
- Latency:
  - Request to ready: 0 cycles.
  - Read grant in cycle N returns rvalid and data in cycle N+1.
  - Write grant in cycle N takes effect in the SPRAM at the clock edge ending cycle N.
- Throughput: 1 access per cycle in aggregate.
- Worst-case port B wait under continuous port A traffic is `STARVE_LIMIT` cycles. Grant occurs in wait cycle `STARVE_LIMIT`+1.
- Simultaneous requests with `wait_cnt < STARVE_LIMIT`: A wins and B's counter increments.
- Reset asserted mid-read: the pending rvalid is dropped, and no response is delivered after reset release.
- Read-after-write to the same address from different ports in consecutive cycles returns the new data, because SPRAM is write-then-read across the cycle boundary.

## Test plan
- **Single reads:** preload word 0x0010 = 0xDEADBEEF. Assert a B read at address 0x0010 with A idle. Require `b_ready` = 1 in the same cycle and `b_rvalid` = 1 with `b_rdata` = 0xDEADBEEF in the next cycle. Require `a_rvalid` = 0 throughout.
- **Contention and starvation:** hold `a_valid` = 1 (reads) and `b_valid` = 1 continuously with `STARVE_LIMIT` = 4. Require the grant pattern A,A,A,A,B repeating. Require `wait_cnt` to go 0→4 and then clear.
- **Masked write:**
  - Port A writes 0x11223344 with mask 1111 to address 0x0100.
  - Port B then writes 0xAABBCCDD with mask 0101 to address 0x0100.
  - Port A reads address 0x0100. Require 0x11BB33DD.
- **Pipelined interleave:** alternate A-read at address 1, B-read at address 2, A-read at address 3 in successive cycles, with the words preloaded to 1, 2 and 3. Require the rvalid sequence a,b,a one cycle delayed, with data 1, 2, 3.
- **Reset mid-read:** issue an A read and deassert `rstn` before the next rising edge. Require `a_rvalid` = 0 immediately and after release. Require `wait_cnt` = 0.
- **Idle:** no valids for 10 cycles. Require `mem_write` = 0, both readys = 0 and both rvalids = 0.
